// File: rtl/img_pkg.sv
// Shared image-pipeline constants: default geometry, pixel width and the
// slot numbering used to pack a 3x3 window into one flat vector.
package img_pkg;

  localparam int PIX_W      = 8;
  localparam int IMG_WIDTH  = 640;
  localparam int IMG_HEIGHT = 480;
  localparam int WIN_W      = 9 * PIX_W;

  // Slot n occupies bits [n*PIX_W +: PIX_W] of a packed window; p00 is the top slot.
  localparam int P00 = 8;
  localparam int P01 = 7;
  localparam int P02 = 6;
  localparam int P10 = 5;
  localparam int P11 = 4;
  localparam int P12 = 3;
  localparam int P20 = 2;
  localparam int P21 = 1;
  localparam int P22 = 0;

  // Slot index of row r, column k inside the window.
  function automatic int win_slot(input int r, input int k);
    return P00 - (3 * r + k);
  endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line memory: one write port and one registered read port.
// A read and write to the same address in one cycle returns the old data.
module line_ram #(
  parameter int DEPTH = 640,
  parameter int DW    = 8
) (
  input  logic                     iClk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DW-1:0]            o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge iClk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/line_window_3x3.sv
// Raster-order pixel stream to registered 3x3 neighbourhood windows.
// Only fully-interior windows are emitted; two line memories hold rows y-1 and y-2.
module line_window_3x3 #(
  parameter int IMG_WIDTH  = img_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = img_pkg::IMG_HEIGHT,
  parameter int PIX_W      = img_pkg::PIX_W
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iValid,
  input  logic [PIX_W-1:0]   iData,
  output logic               oValid,
  output logic [9*PIX_W-1:0] oWin,
  output logic [9:0]         oX,
  output logic [8:0]         oY,
  output logic               oFrameDone
);

  localparam int         AW       = $clog2(IMG_WIDTH);
  localparam logic [9:0] COL_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [8:0] ROW_LAST = 9'(IMG_HEIGHT - 1);

  logic [9:0]         r_col;
  logic [8:0]         r_row;

  logic               r1_valid;
  logic [PIX_W-1:0]   r1_pix;
  logic [9:0]         r1_col;
  logic [8:0]         r1_row;

  logic [PIX_W-1:0]   w_line0_q;
  logic [PIX_W-1:0]   w_line1_q;
  logic [PIX_W-1:0]   w_newcol [3];

  logic [PIX_W-1:0]   r_win [3][3];
  logic               r2_valid;
  logic [9:0]         r2_col;
  logic [8:0]         r2_row;

  logic [9*PIX_W-1:0] w_win_flat;
  logic               w_win_ok;
  logic               w_last_win;

  logic               r_ovalid;
  logic [9*PIX_W-1:0] r_owin;
  logic [9:0]         r_ox;
  logic [8:0]         r_oy;
  logic               r_odone;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (iValid) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 9'd1;
      end else begin
        r_col <= r_col + 10'd1;
      end
    end
  end

  // line1 takes the old line0 word one cycle later, once line0's registered read is out.
  line_ram #(.DEPTH(IMG_WIDTH), .DW(PIX_W)) u_line0 (
    .iClk    (iClk),
    .i_we    (iValid),
    .i_waddr (r_col[AW-1:0]),
    .i_wdata (iData),
    .i_re    (iValid),
    .i_raddr (r_col[AW-1:0]),
    .o_rdata (w_line0_q)
  );

  line_ram #(.DEPTH(IMG_WIDTH), .DW(PIX_W)) u_line1 (
    .iClk    (iClk),
    .i_we    (r1_valid),
    .i_waddr (r1_col[AW-1:0]),
    .i_wdata (w_line0_q),
    .i_re    (iValid),
    .i_raddr (r_col[AW-1:0]),
    .o_rdata (w_line1_q)
  );

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r1_valid <= 1'b0;
      r1_pix   <= '0;
      r1_col   <= '0;
      r1_row   <= '0;
    end else begin
      r1_valid <= iValid;
      if (iValid) begin
        r1_pix <= iData;
        r1_col <= r_col;
        r1_row <= r_row;
      end
    end
  end

  assign w_newcol[0] = w_line1_q;
  assign w_newcol[1] = w_line0_q;
  assign w_newcol[2] = r1_pix;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          r_win[r][k] <= '0;
        end
      end
      r2_valid <= 1'b0;
      r2_col   <= '0;
      r2_row   <= '0;
    end else begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
          r_win[r][2] <= w_newcol[r];
        end
        r2_col <= r1_col;
        r2_row <= r1_row;
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gk = 0; gk < 3; gk++) begin : g_col
      assign w_win_flat[img_pkg::win_slot(gi, gk)*PIX_W +: PIX_W] = r_win[gi][gk];
    end
  end

  // Columns left over from the previous line are only flushed out by col 2.
  assign w_win_ok   = r2_valid && (r2_col >= 10'd2) && (r2_row >= 9'd2);
  assign w_last_win = (r2_col == COL_LAST) && (r2_row == ROW_LAST);

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_ovalid <= 1'b0;
      r_odone  <= 1'b0;
      r_owin   <= '0;
      r_ox     <= '0;
      r_oy     <= '0;
    end else begin
      r_ovalid <= w_win_ok;
      r_odone  <= w_win_ok && w_last_win;
      if (w_win_ok) begin
        r_owin <= w_win_flat;
        r_ox   <= r2_col - 10'd1;
        r_oy   <= r2_row - 9'd1;
      end
    end
  end

  assign oValid     = r_ovalid;
  assign oWin       = r_owin;
  assign oX         = r_ox;
  assign oY         = r_oy;
  assign oFrameDone = r_odone;

endmodule

// File: tb/tb_line_window_3x3.sv
// Scoreboard bench for line_window_3x3 on an 8x6 ramp image: the driver queues
// the expected windows, a negedge monitor pops and compares each output.
module tb_line_window_3x3;

  localparam int W = 8;
  localparam int H = 6;

  logic        iClk;
  logic        iRst;
  logic        iValid;
  logic [7:0]  iData;
  logic        oValid;
  logic [71:0] oWin;
  logic [9:0]  oX;
  logic [8:0]  oY;
  logic        oFrameDone;

  line_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iValid     (iValid),
    .iData      (iData),
    .oValid     (oValid),
    .oWin       (oWin),
    .oX         (oX),
    .oY         (oY),
    .oFrameDone (oFrameDone)
  );

  typedef struct {
    logic [71:0] win;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        done;
    int          t;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_win    = 0;
  int          n_done   = 0;
  int          cyc      = 0;
  logic [71:0] last_win = '0;
  logic [9:0]  last_x   = '0;
  logic [8:0]  last_y   = '0;

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Ramp pixel at (x,y) is base + y*W + x.
  function automatic logic [71:0] model_win(input int base, input int x, input int y);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        w[(8 - (3*r + k))*8 +: 8] = 8'(base + (y - 2 + r)*W + (x - 2 + k));
      end
    end
    return w;
  endfunction

  task automatic drive_frame(input int base, input int gap_pct, input int npix, input bit exp_en);
    for (int i = 0; i < npix; i++) begin
      int x;
      int y;
      x = i % W;
      y = i / W;
      while ($urandom_range(0, 99) < gap_pct) begin
        iValid = 1'b0;
        @(posedge iClk); #1;
      end
      iValid = 1'b1;
      iData  = 8'(base + i);
      @(posedge iClk); #1;
      if (exp_en && x >= 2 && y >= 2) begin
        q.push_back('{model_win(base, x, y), 10'(x - 1), 9'(y - 1),
                      (x == W - 1 && y == H - 1), cyc});
      end
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    iValid = 1'b0;
    while (q.size() != 0 && k < 20) begin
      @(posedge iClk); #1;
      k++;
    end
    repeat (3) begin
      @(posedge iClk); #1;
    end
    chk({name, "_pending"}, 72'(q.size()), 72'd0);
    q.delete();
  endtask

  always @(negedge iClk) begin
    if (!iRst) begin
      last_win = '0;
      last_x   = '0;
      last_y   = '0;
    end else if (oValid) begin
      n_win++;
      if (oFrameDone) n_done++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_window: got centre (%0d,%0d), required no window", oX, oY);
      end else begin
        e = q.pop_front();
        chk("win", oWin, e.win);
        chk("x", 72'(oX), 72'(e.x));
        chk("y", 72'(oY), 72'(e.y));
        chk("frame_done", 72'(oFrameDone), 72'(e.done));
        chk("latency", 72'(cyc - e.t), 72'd2);
        $display("window (%0d,%0d) win=%018h done=%0b", oX, oY, oWin, oFrameDone);
      end
      last_win = oWin;
      last_x   = oX;
      last_y   = oY;
    end else begin
      chk("hold_win", oWin, last_win);
      chk("hold_x", 72'(oX), 72'(last_x));
      chk("hold_y", 72'(oY), 72'(last_y));
      chk("idle_done", 72'(oFrameDone), 72'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    iRst   = 1'b0;
    iValid = 1'b0;
    iData  = '0;

    // Reset held with iValid toggling: every output must sit at zero.
    for (int i = 0; i < 6; i++) begin
      iValid = ~iValid;
      iData  = 8'($urandom);
      @(negedge iClk);
      chk("rst_valid", 72'(oValid), 72'd0);
      chk("rst_win", oWin, 72'd0);
      chk("rst_x", 72'(oX), 72'd0);
      chk("rst_y", 72'(oY), 72'd0);
      chk("rst_done", 72'(oFrameDone), 72'd0);
      @(posedge iClk); #1;
    end
    iValid = 1'b0;
    iRst   = 1'b1;
    @(posedge iClk); #1;

    // Continuous ramp frame.
    n_win = 0; n_done = 0;
    drive_frame(0, 0, W*H, 1'b1);
    drain("cont");
    chk("cont_windows", 72'(n_win), 72'd24);
    chk("cont_done_count", 72'(n_done), 72'd1);

    // Same ramp with ~40% idle cycles.
    n_win = 0; n_done = 0;
    drive_frame(0, 40, W*H, 1'b1);
    drain("gaps");
    chk("gaps_windows", 72'(n_win), 72'd24);
    chk("gaps_done_count", 72'(n_done), 72'd1);

    // Two back-to-back frames, second offset by 0x40.
    n_win = 0; n_done = 0;
    drive_frame(0, 0, W*H, 1'b1);
    drive_frame(8'h40, 0, W*H, 1'b1);
    drain("two_frames");
    chk("two_windows", 72'(n_win), 72'd48);
    chk("two_done_count", 72'(n_done), 72'd2);

    // Reset after 20 pixels (two windows in flight), then a clean frame.
    n_win = 0; n_done = 0;
    drive_frame(8'h80, 0, 20, 1'b0);
    iRst   = 1'b0;
    iValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      chk("midrst_valid", 72'(oValid), 72'd0);
      chk("midrst_win", oWin, 72'd0);
    end
    @(posedge iClk); #1;
    iRst = 1'b1;
    drive_frame(0, 0, W*H, 1'b1);
    drain("midrst");
    chk("midrst_windows", 72'(n_win), 72'd24);
    chk("midrst_done_count", 72'(n_done), 72'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
